muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage of the pipelined RV32I core. It accepts one M-extension operation at a time and computes it over a fixed sequence of cycles: shift-add for multiply, restoring division for divide and remainder. While it works it holds the pipeline with a stall output. A one-cycle `valid` pulse returns the 32-bit result for writeback.

---
 rtl/muldiv_unit_pkg.sv | 35 +++
 rtl/muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit.
// Contents: muldiv_op_t (funct3 encodings), muldiv_state_t (FSM states),
// MULDIV_ITER (iterations per operation), two's-complement helper functions.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_t;

  localparam int MULDIV_ITER = 32;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add multiply, restoring divide).
// Ports:
//   clk, reset_n (sync, active-low)
//   start, md_op, src_a, src_b : operation request from execute stage
//   flush                      : abort the operation in progress
//   busy                       : FSM not idle
//   stall_e                    : hold fetch/decode/execute while working
//   valid, result              : one-cycle result pulse, result held until next valid
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  muldiv_op_t      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_e,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [5:0] ITER_LAST = 6'(MULDIV_ITER - 1);

  muldiv_state_t     state_r;
  muldiv_state_t     state_next_s;
  muldiv_op_t        op_r;
  // Multiply: {product high, multiplier remaining}. Divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_r;
  logic [XLEN-1:0]   opnd_r;
  logic [5:0]        cnt_r;
  logic              neg_r;
  logic [XLEN-1:0]   result_r;
  logic              valid_r;

  logic              a_neg_s;
  logic              b_neg_s;
  logic [XLEN-1:0]   a_abs_s;
  logic [XLEN-1:0]   b_abs_s;
  logic              is_div_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   special_res_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN+1:0]   div_diff_s;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   fix_res_s;

  // Operand signedness, absolute values and early-exit detection (valid in PREP).
  always_comb begin
    is_div_s   = op_r[2];
    a_neg_s    = ((op_r == MD_MULH) || (op_r == MD_MULHSU) ||
                  (op_r == MD_DIV)  || (op_r == MD_REM)) && acc_r[XLEN-1];
    b_neg_s    = ((op_r == MD_MULH) || (op_r == MD_DIV) || (op_r == MD_REM)) &&
                 opnd_r[XLEN-1];
    a_abs_s    = a_neg_s ? neg32(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
    b_abs_s    = b_neg_s ? neg32(opnd_r) : opnd_r;
    div_zero_s = is_div_s && (opnd_r == 32'd0);
    div_ovf_s  = ((op_r == MD_DIV) || (op_r == MD_REM)) &&
                 (acc_r[XLEN-1:0] == 32'h8000_0000) && (opnd_r == 32'hFFFF_FFFF);
    special_s  = div_zero_s || div_ovf_s;
    // op_r[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero_s) begin
      special_res_s = op_r[1] ? acc_r[XLEN-1:0] : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op_r[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One shift-add or restoring-divide iteration on the accumulator.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
    // Shifted partial remainder minus divisor; bit 33 set means it did not fit.
    div_diff_s = {1'b0, acc_r[2*XLEN-1:XLEN-1]} - {2'b00, opnd_r};
    if (is_div_s) begin
      if (!div_diff_s[XLEN+1]) begin
        step_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_s = {acc_r[2*XLEN-2:0], 1'b0};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
  end

  // Sign correction and output selection for FIX.
  always_comb begin
    prod_s = neg_r ? neg64(acc_r) : acc_r;
    case (op_r)
      MD_MUL:                       fix_res_s = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fix_res_s = neg_r ? neg32(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
      MD_REM, MD_REMU:              fix_res_s = neg_r ? neg32(acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
      default:                      fix_res_s = 32'd0;
    endcase
  end

  // Next-state logic; flush aborts every working state but DONE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && !flush) state_next_s = ST_PREP;
        else                 state_next_s = ST_IDLE;
      end
      ST_PREP: begin
        if (flush)          state_next_s = ST_IDLE;
        else if (special_s) state_next_s = ST_DONE;
        else                state_next_s = ST_CALC;
      end
      ST_CALC: begin
        if (flush)                   state_next_s = ST_IDLE;
        else if (cnt_r == ITER_LAST) state_next_s = ST_FIX;
        else                         state_next_s = ST_CALC;
      end
      ST_FIX: begin
        if (flush) state_next_s = ST_IDLE;
        else       state_next_s = ST_DONE;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and registered valid pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      valid_r <= (state_next_s == ST_DONE);
    end
  end

  // Datapath registers: operand capture, preparation, iteration, result.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_r     <= MD_MUL;
      acc_r    <= 64'd0;
      opnd_r   <= 32'd0;
      cnt_r    <= 6'd0;
      neg_r    <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start && !flush) begin
            op_r   <= md_op;
            acc_r  <= {32'd0, src_a};
            opnd_r <= src_b;
          end
        end
        ST_PREP: begin
          cnt_r <= 6'd0;
          if (!flush) begin
            // Remainder takes the dividend sign; everything else the xor of signs.
            neg_r <= (op_r == MD_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);
            if (special_s) begin
              result_r <= special_res_s;
            end else if (is_div_s) begin
              acc_r  <= {32'd0, a_abs_s};
              opnd_r <= b_abs_s;
            end else begin
              acc_r  <= {32'd0, b_abs_s};
              opnd_r <= a_abs_s;
            end
          end
        end
        ST_CALC: begin
          if (flush) begin
            cnt_r <= 6'd0;
          end else begin
            acc_r <= step_s;
            cnt_r <= cnt_r + 6'd1;
          end
        end
        ST_FIX: begin
          if (!flush) result_r <= fix_res_s;
        end
        default: begin
          cnt_r <= 6'd0;
        end
      endcase
    end
  end

  assign busy    = (state_r != ST_IDLE);
  assign stall_e = ((state_r == ST_IDLE) && start && !flush) ||
                   (state_r == ST_PREP) || (state_r == ST_CALC) || (state_r == ST_FIX);
  assign valid   = valid_r;
  assign result  = result_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus random ops,
// results compared against an arithmetic reference model through a scoreboard.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        flush;
  muldiv_op_t  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        stall_e;
  logic        valid;
  logic [31:0] result;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'd0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .flush(flush), .busy(busy),
    .stall_e(stall_e), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions, using 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input muldiv_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MUL:    begin p = ua * ub;            return p[31:0];  end
      MD_MULH:   begin p = sa * sb;            return p[63:32]; end
      MD_MULHSU: begin p = sa * longint'(ub);  return p[63:32]; end
      MD_MULHU:  begin p = ua * ub;            return p[63:32]; end
      MD_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      MD_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      MD_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input muldiv_op_t op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 32'd0) return 2;
    if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 35;
  endfunction

  // Scoreboard monitor: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=%0h required=no_valid", result);
      end else begin
        check("result", {32'd0, result}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  // Issue one op at a negedge in IDLE. abort_kind: 0 none, 1 flush, 2 reset.
  task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input bit hold_start, input int abort_kind, input int abort_cyc);
    int          lat;
    int          seen;
    bit          done;
    bit          stall_ok;
    logic [31:0] exp;
    lat      = ref_latency(op, a, b);
    exp      = ref_model(op, a, b);
    seen     = 0;
    done     = 1'b0;
    stall_ok = 1'b1;
    md_op    = op;
    src_a    = a;
    src_b    = b;
    start    = 1'b1;
    #1;
    check("stall_accept", {63'd0, stall_e}, 64'd1);
    if (abort_kind == 0) exp_q.push_back(exp);
    @(posedge clk);
    for (int n = 1; n <= 60 && !done; n++) begin
      @(negedge clk);
      if (abort_kind == 0) begin
        if (stall_e !== (n < lat) || busy !== 1'b1) stall_ok = 1'b0;
        if (valid) begin
          seen = n;
          done = 1'b1;
        end
      end else if (n == abort_cyc + 1) begin
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_stall", {63'd0, stall_e}, 64'd0);
        check("abort_valid", {63'd0, valid}, 64'd0);
        check("abort_result", {32'd0, result}, {32'd0, (abort_kind == 2) ? 32'd0 : last_result});
        flush   = 1'b0;
        reset_n = 1'b1;
        done    = 1'b1;
      end else if (n == abort_cyc) begin
        if (abort_kind == 1) flush = 1'b1;
        else reset_n = 1'b0;
      end
      // Operand changes after acceptance must not affect the result.
      if (n == 1) begin
        src_a = $urandom;
        src_b = $urandom;
        if (!hold_start) start = 1'b0;
      end
      if (n == lat - 1) start = 1'b0;
    end
    if (abort_kind == 0) begin
      check("latency", 64'(seen), 64'(lat));
      check("stall_busy_profile", {63'd0, stall_ok}, 64'd1);
      last_result = exp;
    end else begin
      if (abort_kind == 2) last_result = 32'd0;
      repeat (40) @(negedge clk);
      check("result_held", {32'd0, result}, {32'd0, last_result});
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return $urandom_range(0, 255);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    md_op   = MD_MUL;
    src_a   = 32'd0;
    src_b   = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_stall", {63'd0, stall_e}, 64'd0);
    check("reset_valid", {63'd0, valid}, 64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 1'b0, 0, 0);
    run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, 1'b0, 0, 0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         1'b0, 0, 0);
    run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         1'b0, 0, 0);
    run_op(MD_DIVU,   32'd100,        32'd7,         1'b0, 0, 0);
    run_op(MD_REMU,   32'd100,        32'd7,         1'b0, 0, 0);
    run_op(MD_DIVU,   32'd5,          32'd0,         1'b0, 0, 0);
    run_op(MD_REM,    32'd5,          32'd0,         1'b0, 0, 0);
    run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(MD_MUL,    32'h1234_5678,  32'h0000_0100, 1'b1, 0, 0);
    run_op(MD_DIV,    32'd1000,       32'd3,         1'b0, 1, 10);
    run_op(MD_DIVU,   32'd1000,       32'd3,         1'b0, 0, 0);
    run_op(MD_MUL,    32'd123,        32'd456,       1'b0, 2, 20);
    run_op(MD_MUL,    32'd6,          32'd7,         1'b0, 0, 0);

    for (int i = 0; i < 24; i++) begin
      muldiv_op_t  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = muldiv_op_t'($urandom_range(0, 7));
      ra  = pick_operand();
      rb  = pick_operand();
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), 0, 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
